// File: rtl/branch_ctrl_if.sv
// Request/result bundle between decode, branch_ctrl and the PC mux.
// master = decode/fetch side, slave = branch_ctrl.
interface branch_ctrl_if #(
  parameter int XLEN = 32
);
  logic            br_valid;
  logic            br_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] imm;
  logic            res_valid;
  logic            res_ready;
  logic            taken;
  logic [XLEN-1:0] target;
  logic            flush;
  logic            illegal;
  logic            misalign;

  modport master (
    output br_valid, opcode, funct3, pc, rs1, rs2, imm, res_ready,
    input  br_ready, res_valid, taken, target, flush, illegal, misalign
  );

  modport slave (
    input  br_valid, opcode, funct3, pc, rs1, rs2, imm, res_ready,
    output br_ready, res_valid, taken, target, flush, illegal, misalign
  );
endinterface

// File: rtl/branch_ctrl.sv
// Branch/jump resolution sequencer: IDLE -> EVAL -> RESP, one request at a time.
// Optional macro BR_STATS_EN adds saturating branch / taken-branch counters.
module branch_ctrl #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  branch_ctrl_if.slave bus
`ifdef BR_STATS_EN
  ,
  output logic [31:0]  br_cnt,
  output logic [31:0]  taken_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t state, state_nxt;

  logic [6:0]             opcode_p0;
  logic [2:0]             funct3_p0;
  logic [XLEN-1:0]        pc_p0;
  logic signed [XLEN-1:0] rs1_p0;
  logic signed [XLEN-1:0] rs2_p0;
  logic [XLEN-1:0]        imm_p0;

  logic                   cond_c, illegal_c, misalign_c, taken_c;
  logic                   eq_c, lt_c, ltu_c;
  logic [XLEN-1:0]        target_c, jalr_sum_c;

  logic                   taken_p1, illegal_p1, misalign_p1, first_p1;
  logic [XLEN-1:0]        target_p1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; requests arriving outside IDLE are simply not accepted
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.br_valid) state_nxt = EVAL;
      EVAL:    state_nxt = RESP;
      RESP:    if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.br_ready  = (state == IDLE);
    bus.res_valid = (state == RESP);
    bus.flush     = (state == RESP) && first_p1 && taken_p1;
  end

  assign bus.taken    = taken_p1;
  assign bus.target   = target_p1;
  assign bus.illegal  = illegal_p1;
  assign bus.misalign = misalign_p1;

  // ---- p0: request capture (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.br_valid) begin
      opcode_p0 <= bus.opcode;
      funct3_p0 <= bus.funct3;
      pc_p0     <= bus.pc;
      rs1_p0    <= bus.rs1;
      rs2_p0    <= bus.rs2;
      imm_p0    <= bus.imm;
    end
  end

  // ---- EVAL: condition and target from captured operands ----
  always_comb begin
    eq_c       = (rs1_p0 == rs2_p0);
    lt_c       = (rs1_p0 < rs2_p0);
    ltu_c      = ($unsigned(rs1_p0) < $unsigned(rs2_p0));
    jalr_sum_c = $unsigned(rs1_p0) + imm_p0;
    cond_c     = 1'b0;
    illegal_c  = 1'b0;
    target_c   = pc_p0 + imm_p0;
    unique case (opcode_p0)
      OP_BRANCH: begin
        unique case (funct3_p0)
          3'b000:  cond_c = eq_c;
          3'b001:  cond_c = !eq_c;
          3'b100:  cond_c = lt_c;
          3'b101:  cond_c = !lt_c;
          3'b110:  cond_c = ltu_c;
          3'b111:  cond_c = !ltu_c;
          default: illegal_c = 1'b1;
        endcase
      end
      OP_JAL:  cond_c = 1'b1;
      OP_JALR: begin
        cond_c   = 1'b1;
        target_c = {jalr_sum_c[XLEN-1:1], 1'b0};
      end
      default: illegal_c = 1'b1;
    endcase
    misalign_c = cond_c && target_c[1];
    taken_c    = cond_c && !target_c[1];
  end

  // ---- p1: registered result, held until the next EVAL ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_p1    <= 1'b0;
      illegal_p1  <= 1'b0;
      misalign_p1 <= 1'b0;
      target_p1   <= '0;
      first_p1    <= 1'b0;
    end else begin
      first_p1 <= (state == EVAL);
      if (state == EVAL) begin
        taken_p1    <= taken_c;
        illegal_p1  <= illegal_c;
        misalign_p1 <= misalign_c;
        target_p1   <= target_c;
      end
    end
  end

`ifdef BR_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic br_done;
  assign br_done = (state == RESP) && bus.res_ready &&
                   (opcode_p0 == OP_BRANCH) && !illegal_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt    <= '0;
      taken_cnt <= '0;
    end else if (br_done) begin
      br_cnt <= sat_inc(br_cnt);
      if (taken_p1) taken_cnt <= sat_inc(taken_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl; define BR_STATS_EN to also check counters.
module tb_branch_ctrl;
  localparam int XLEN = 32;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ALU    = 7'b0110011;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_ctrl_if #(.XLEN(XLEN)) bif();

`ifdef BR_STATS_EN
  logic [31:0] br_cnt, taken_cnt;
`endif

  branch_ctrl #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
`ifdef BR_STATS_EN
    ,
    .br_cnt    (br_cnt),
    .taken_cnt (taken_cnt)
`endif
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic set_req(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    bif.opcode = op;
    bif.funct3 = f3;
    bif.pc     = pc;
    bif.rs1    = rs1;
    bif.rs2    = rs2;
    bif.imm    = imm;
  endtask

  // Issue one request; returns at the negedge of the first RESP cycle.
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    @(negedge clk);
    set_req(op, f3, pc, rs1, rs2, imm);
    bif.br_valid  = 1'b1;
    bif.res_ready = 1'b0;
    @(negedge clk);
    bif.br_valid = 1'b0;
    chk_b("eval_res_valid", bif.res_valid, 1'b0);
    @(negedge clk);
    chk_b("resp_res_valid", bif.res_valid, 1'b1);
  endtask

  task automatic finish_resp();
    bif.res_ready = 1'b1;
    @(negedge clk);
    bif.res_ready = 1'b0;
    chk_b("idle_br_ready", bif.br_ready, 1'b1);
    chk_b("idle_res_valid", bif.res_valid, 1'b0);
  endtask

  initial begin
    rst           = 1'b1;
    bif.br_valid  = 1'b0;
    bif.res_ready = 1'b0;
    set_req('0, '0, '0, '0, '0, '0);
    repeat (2) @(negedge clk);
    chk_b("rst_br_ready", bif.br_ready, 1'b1);
    chk_b("rst_res_valid", bif.res_valid, 1'b0);
    chk_b("rst_taken", bif.taken, 1'b0);
    chk_b("rst_flush", bif.flush, 1'b0);
    chk_b("rst_illegal", bif.illegal, 1'b0);
    chk_b("rst_misalign", bif.misalign, 1'b0);
    chk("rst_target", bif.target, 32'h0);
    rst = 1'b0;

    // BEQ taken, flush exactly one cycle
    send(OP_BRANCH, 3'b000, 32'h100, 32'h1234_5678, 32'h1234_5678, 32'h20);
    chk_b("beq_taken", bif.taken, 1'b1);
    chk("beq_target", bif.target, 32'h120);
    chk_b("beq_flush1", bif.flush, 1'b1);
    chk_b("beq_illegal", bif.illegal, 1'b0);
    @(negedge clk);
    chk_b("beq_flush2", bif.flush, 1'b0);
    chk_b("beq_valid2", bif.res_valid, 1'b1);
    finish_resp();
    chk_b("beq_flush_idle", bif.flush, 1'b0);

    // Signed vs unsigned less-than
    send(OP_BRANCH, 3'b100, 32'h200, 32'hFFFF_FFFF, 32'h1, 32'h10);
    chk_b("blt_taken", bif.taken, 1'b1);
    chk("blt_target", bif.target, 32'h210);
    finish_resp();
    send(OP_BRANCH, 3'b110, 32'h200, 32'hFFFF_FFFF, 32'h1, 32'h10);
    chk_b("bltu_taken", bif.taken, 1'b0);
    chk_b("bltu_flush", bif.flush, 1'b0);
    chk("bltu_target", bif.target, 32'h210);
    finish_resp();

    // JALR misaligned, JAL wrap-around
    send(OP_JALR, 3'b000, 32'h40, 32'h0000_1003, 32'h0, 32'h4);
    chk("jalr_target", bif.target, 32'h0000_1006);
    chk_b("jalr_misalign", bif.misalign, 1'b1);
    chk_b("jalr_taken", bif.taken, 1'b0);
    chk_b("jalr_flush", bif.flush, 1'b0);
    finish_resp();
    send(OP_JAL, 3'b101, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h8);
    chk("jal_target", bif.target, 32'h0000_0004);
    chk_b("jal_taken", bif.taken, 1'b1);
    chk_b("jal_misalign", bif.misalign, 1'b0);
    chk_b("jal_flush", bif.flush, 1'b1);
    finish_resp();

    // Illegal encodings
    send(OP_BRANCH, 3'b010, 32'h80, 32'h5, 32'h5, 32'h8);
    chk_b("f3_010_illegal", bif.illegal, 1'b1);
    chk_b("f3_010_taken", bif.taken, 1'b0);
    chk_b("f3_010_flush", bif.flush, 1'b0);
    finish_resp();
    send(OP_ALU, 3'b000, 32'h80, 32'h5, 32'h5, 32'h8);
    chk_b("alu_illegal", bif.illegal, 1'b1);
    chk_b("alu_taken", bif.taken, 1'b0);
    chk_b("alu_flush", bif.flush, 1'b0);
    finish_resp();

    // Back-pressure: result held for 5 cycles while a new request waits
    send(OP_BRANCH, 3'b001, 32'h300, 32'h1, 32'h2, 32'h40);
    chk_b("stall_flush_first", bif.flush, 1'b1);
    chk("stall_target0", bif.target, 32'h340);
    set_req(OP_BRANCH, 3'b000, 32'h400, 32'h9, 32'h9, 32'h8);
    bif.br_valid = 1'b1;
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      chk_b("stall_flush", bif.flush, 1'b0);
      chk_b("stall_br_ready", bif.br_ready, 1'b0);
      chk_b("stall_res_valid", bif.res_valid, 1'b1);
      chk_b("stall_taken", bif.taken, 1'b1);
      chk("stall_target", bif.target, 32'h340);
    end
    bif.res_ready = 1'b1;
    @(negedge clk);
    bif.res_ready = 1'b0;
    chk_b("stall_idle_ready", bif.br_ready, 1'b1);
    chk_b("stall_idle_valid", bif.res_valid, 1'b0);
    chk("stall_idle_target", bif.target, 32'h340);
    @(negedge clk);
    bif.br_valid = 1'b0;
    chk_b("second_eval_ready", bif.br_ready, 1'b0);
    chk_b("second_eval_valid", bif.res_valid, 1'b0);
    @(negedge clk);
    chk_b("second_resp_valid", bif.res_valid, 1'b1);
    chk("second_target", bif.target, 32'h408);
    chk_b("second_flush", bif.flush, 1'b1);
    finish_resp();

    // Reset while in EVAL drops the request
    @(negedge clk);
    set_req(OP_BRANCH, 3'b000, 32'h500, 32'h3, 32'h3, 32'h10);
    bif.br_valid = 1'b1;
    @(negedge clk);
    bif.br_valid = 1'b0;
    chk_b("evalrst_pre_ready", bif.br_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk_b("evalrst_ready", bif.br_ready, 1'b1);
    chk_b("evalrst_valid", bif.res_valid, 1'b0);
    chk_b("evalrst_taken", bif.taken, 1'b0);
    chk("evalrst_target", bif.target, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_b("evalrst_no_result", bif.res_valid, 1'b0);
      chk_b("evalrst_no_flush", bif.flush, 1'b0);
    end
`ifdef BR_STATS_EN
    chk("cnt_rst_br", br_cnt, 32'd0);
    chk("cnt_rst_taken", taken_cnt, 32'd0);
`endif

    // Three branches (two taken) and one jump
    send(OP_BRANCH, 3'b000, 32'h600, 32'h7, 32'h7, 32'h4);
    chk_b("s_beq_taken", bif.taken, 1'b1);
    finish_resp();
    send(OP_BRANCH, 3'b100, 32'h600, 32'hFFFF_FFFB, 32'h3, 32'h4);
    chk_b("s_blt_taken", bif.taken, 1'b1);
    finish_resp();
    send(OP_BRANCH, 3'b110, 32'h600, 32'hFFFF_FFFB, 32'h3, 32'h4);
    chk_b("s_bltu_taken", bif.taken, 1'b0);
    finish_resp();
    send(OP_JAL, 3'b000, 32'h600, 32'h0, 32'h0, 32'h100);
    chk("s_jal_target", bif.target, 32'h700);
    finish_resp();
`ifdef BR_STATS_EN
    chk("cnt_br", br_cnt, 32'd3);
    chk("cnt_taken", taken_cnt, 32'd2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
